// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the RISC-V M-extension multiply ops.
// Operands are converted to magnitudes at start. One shift-add step runs per
// RUN cycle, and the product's sign is applied on entry to DONE.
module mul_sequencer #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CYCLES = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [2:0]       funct3_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [1:0]           op_q, op_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     result_q, result_d;

   logic                 a_sgn, b_sgn;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   prod_step, prod_final;
   logic                 unused_funct3;

   // Bit 2 of funct3 does not distinguish the multiply variants.
   assign unused_funct3 = funct3_i[2];

   // Operand signedness, magnitudes and one shift-add step of the datapath.
   always_comb begin
      a_sgn      = (funct3_i[1:0] != 2'b11) && a_i[WIDTH-1];
      b_sgn      = !funct3_i[1] && b_i[WIDTH-1];
      a_mag      = a_sgn ? (~a_i + 1'b1) : a_i;
      b_mag      = b_sgn ? (~b_i + 1'b1) : b_i;
      sum        = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      // Carry shifts into the product MSB.
      prod_step  = {sum, prod_q[WIDTH-1:1]};
      prod_final = neg_q ? (~prod_step + 1'b1) : prod_step;
   end

   // Next-state logic and next values for the FSM and datapath registers.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               op_d     = funct3_i[1:0];
               neg_d    = a_sgn ^ b_sgn;
               prod_d   = '0;
               cnt_d    = CntW'(CYCLES - 1);
               state_d  = StRun;
            end
         end
         StRun: begin
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
               prod_d   = prod_final;
               result_d = (op_q == 2'b00) ? prod_final[WIDTH-1:0]
                                          : prod_final[2*WIDTH-1:WIDTH];
               state_d  = StDone;
            end else begin
               prod_d = prod_step;
               cnt_d  = cnt_q - 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   // Status outputs; stall covers the decode cycle before RUN is entered.
   always_comb begin
      stall_o  = ((state_q == StIdle) && start_i) || (state_q == StRun);
      busy_o   = (state_q == StRun);
      done_o   = (state_q == StDone);
      result_o = result_q;
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: latency, stall/done timing, all four
// multiply variants, back-to-back issue, mid-run reset and operand changes.
module tb_mul_sequencer;

   logic        clk;
   logic        reset;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int n_tests = 0;
   int n_fail  = 0;

   mul_sequencer #(.WIDTH(32), .CYCLES(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start_i  (start_i),
      .funct3_i (funct3_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .stall_o  (stall_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one multiply with start_i held high until done_o; cycle 0 is the
   // first cycle start_i is high. Returns the done cycle (-1 if none in budget).
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit rnd, output logic [31:0] res, output int done_cyc,
                         output int stall_cnt, output int busy_cnt);
      @(posedge clk); #1;
      start_i  = 1'b1;
      funct3_i = f;
      a_i      = a;
      b_i      = b;
      done_cyc  = -1;
      stall_cnt = 0;
      busy_cnt  = 0;
      res       = '0;
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (busy_o)  busy_cnt++;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (rnd) begin
            a_i      = $urandom;
            b_i      = $urandom;
            funct3_i = 3'($urandom);
         end
         @(negedge clk);
         if (done_o) begin
            done_cyc = c;
            res      = result_o;
            check("stall_in_done", {63'd0, stall_o}, 64'd0);
            break;
         end
         if (stall_o) stall_cnt++;
         if (busy_o)  busy_cnt++;
      end
   endtask

   task automatic expect_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input bit rnd, input logic [31:0] exp);
      logic [31:0] res;
      int dc, sc, bc;
      run_op(f, a, b, rnd, res, dc, sc, bc);
      check({tag, "_res"}, {32'd0, res}, {32'd0, exp});
      check({tag, "_lat"}, 64'(dc), 64'd33);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         start_i = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] res;
      int dc, sc, bc, dcount;

      reset    = 1'b0;
      start_i  = 1'b0;
      funct3_i = '0;
      a_i      = '0;
      b_i      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy",   {63'd0, busy_o},   64'd0);
      check("rst_done",   {63'd0, done_o},   64'd0);
      check("rst_result", {32'd0, result_o}, 64'd0);
      check("rst_stall0", {63'd0, stall_o},  64'd0);
      start_i = 1'b1;
      #1;
      check("rst_stall1", {63'd0, stall_o},  64'd1);
      @(posedge clk); #1;
      start_i = 1'b0;
      reset   = 1'b1;
      idle_cycles(2);

      // 7*6 with full timing profile
      run_op(3'b000, 32'd7, 32'd6, 1'b0, res, dc, sc, bc);
      check("mul7x6_res",   {32'd0, res}, 64'h2A);
      check("mul7x6_lat",   64'(dc), 64'd33);
      check("mul7x6_stall", 64'(sc), 64'd33);
      check("mul7x6_busy",  64'(bc), 64'd32);
      idle_cycles(1);
      check("after_done",   {63'd0, done_o}, 64'd0);
      check("result_hold",  {32'd0, result_o}, 64'h2A);

      expect_op("mulh_m1x2",     3'b001, 32'hFFFFFFFF, 32'h2,        1'b0, 32'hFFFFFFFF);
      expect_op("mul_m1x2",      3'b000, 32'hFFFFFFFF, 32'h2,        1'b0, 32'hFFFFFFFE);
      expect_op("mulhu_max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE);
      expect_op("mulhsu_max",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF);
      expect_op("mulh_minsq",    3'b001, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000);
      expect_op("mulhsu_min",    3'b010, 32'h80000000, 32'h2,        1'b0, 32'hFFFFFFFF);
      expect_op("mul_3xm5",      3'b100, 32'h3,        32'hFFFFFFFB, 1'b0, 32'hFFFFFFF1);
      expect_op("mulh_3xm5",     3'b101, 32'h3,        32'hFFFFFFFB, 1'b0, 32'hFFFFFFFF);
      expect_op("mulhu_2p32",    3'b111, 32'h00010000, 32'h00010000, 1'b0, 32'h00000001);
      idle_cycles(2);

      // Back-to-back: second start in the IDLE cycle right after DONE
      run_op(3'b000, 32'd3, 32'd5, 1'b0, res, dc, sc, bc);
      check("b2b1_res",   {32'd0, res}, 64'hF);
      check("b2b1_lat",   64'(dc), 64'd33);
      check("b2b1_stall", 64'(sc), 64'd33);
      run_op(3'b000, 32'd0, 32'h12345678, 1'b0, res, dc, sc, bc);
      check("b2b2_res",   {32'd0, res}, 64'h0);
      check("b2b2_lat",   64'(dc + 34), 64'd67);
      check("b2b2_stall", 64'(sc), 64'd33);
      idle_cycles(2);

      // Operands and funct3 scrambled every cycle after the start
      expect_op("rnd_mul",   3'b000, 32'h00001234, 32'h00000100, 1'b1, 32'h00123400);
      expect_op("rnd_mulhu", 3'b011, 32'hDEADBEEF, 32'h00000010, 1'b1, 32'h0000000D);
      idle_cycles(2);

      // Reset asserted in RUN cycle 10 aborts without a done pulse
      @(posedge clk); #1;
      start_i  = 1'b1;
      funct3_i = 3'b000;
      a_i      = 32'd9;
      b_i      = 32'd9;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
      end
      reset   = 1'b0;
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy",   {63'd0, busy_o},   64'd0);
      check("abort_done",   {63'd0, done_o},   64'd0);
      check("abort_result", {32'd0, result_o}, 64'd0);
      check("abort_stall",  {63'd0, stall_o},  64'd0);
      @(posedge clk); #1;
      reset  = 1'b1;
      dcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_o) dcount++;
      end
      check("abort_no_done", 64'(dcount), 64'd0);
      expect_op("mul_after_rst", 3'b000, 32'd2, 32'd3, 1'b0, 32'h6);
      idle_cycles(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time limit so a stuck DUT still ends the run.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before limit");
      $fatal(1, "timeout");
   end

endmodule
